// File: rtl/mem_stage.sv
// mem_stage: data-memory stage with byte/half/word loads and stores,
// signed/unsigned load extension, configurable access latency and
// valid/ready handshakes on the request and response sides.
// Optional build macro MEM_STAGE_WRITE_LOG_EN: prints each committed store.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | req_ready=1, waiting for a request; fields latched on accept
// BUSY  | access in flight, cnt counts down to the commit edge
// RESP  | rsp_valid=1, outputs held until rsp_ready
module mem_stage #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH];

  logic        lat_we, lat_uns, lat_err;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr, lat_wdata, lat_pc;

  logic        req_err;
  logic        op_we, op_uns, op_err;
  logic [1:0]  op_size, op_off;
  logic [31:0] op_addr, op_wdata, op_pc;
  logic [ADDR_WIDTH-1:0] op_idx;
  logic        commit;

  logic [31:0] cur_word, shifted, lane_mask, wdata_rep, merged, load_ext;
  logic [4:0]  lane_sh;

  logic        unused_bits;

  // Misalignment of the incoming request
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'd0:    req_err = 1'b0;
      2'd1:    req_err = req_addr[0];
      2'd2:    req_err = (req_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
  end

  // The commit edge out of IDLE uses the live request; out of BUSY, the latched copy
  always_comb begin
    op_we    = lat_we;
    op_uns   = lat_uns;
    op_err   = lat_err;
    op_size  = lat_size;
    op_addr  = lat_addr;
    op_wdata = lat_wdata;
    op_pc    = lat_pc;
    if (state == IDLE) begin
      op_we    = req_we;
      op_uns   = req_unsigned;
      op_err   = req_err;
      op_size  = req_size;
      op_addr  = req_addr;
      op_wdata = req_wdata;
      op_pc    = req_pc;
    end
  end

  assign op_idx  = op_addr[ADDR_WIDTH+1:2];
  assign op_off  = op_addr[1:0];
  assign lane_sh = {op_off, 3'b000};
  assign unused_bits = ^{op_addr[31:ADDR_WIDTH+2], op_pc};

  // Lane merge for stores and shift/extend for loads
  always_comb begin
    cur_word  = mem[op_idx];
    shifted   = cur_word >> lane_sh;
    lane_mask = 32'hFFFF_FFFF;
    wdata_rep = op_wdata;
    load_ext  = cur_word;
    case (op_size)
      2'd0: begin
        lane_mask = 32'h0000_00FF << lane_sh;
        wdata_rep = {4{op_wdata[7:0]}};
        load_ext  = op_uns ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'd1: begin
        lane_mask = 32'h0000_FFFF << {op_off[1], 4'b0000};
        wdata_rep = {2{op_wdata[15:0]}};
        load_ext  = op_uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        lane_mask = 32'hFFFF_FFFF;
        wdata_rep = op_wdata;
        load_ext  = cur_word;
      end
    endcase
    merged = (cur_word & ~lane_mask) | (wdata_rep & lane_mask);
  end

  // Next-state and commit decision
  always_comb begin
    state_nx = state;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err || LATENCY == 1) begin
            state_nx = RESP;
            commit   = 1'b1;
          end else begin
            state_nx = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt <= 4'd1) begin
          state_nx = RESP;
          commit   = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // State, latency counter, latched request and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_uns   <= 1'b0;
      lat_err   <= 1'b0;
      lat_size  <= 2'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_pc    <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        lat_we    <= req_we;
        lat_uns   <= req_unsigned;
        lat_err   <= req_err;
        lat_size  <= req_size;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_pc    <= req_pc;
        cnt       <= 4'(LATENCY - 1);
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        rsp_err   <= op_err;
        rsp_rdata <= (op_err || op_we) ? 32'd0 : load_ext;
      end
    end
  end

  // Memory array: cleared on reset, written on a store's commit edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else if (commit && op_we && !op_err) begin
      mem[op_idx] <= merged;
`ifdef MEM_STAGE_WRITE_LOG_EN
      $display("@%h: *%h <= %h", op_pc, 32'({op_idx, 2'b00}), merged);
`else
`endif
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Parametrised data-memory stage that replaces the fixed lb/sb data memory of the single-cycle datapath.
- Supports byte, halfword and word loads and stores, signed and unsigned.
- Has a configurable access latency and valid/ready handshakes on both the request and response sides.
- Sits between the ALU address output and the register-file write-back mux; the controller stalls on req_ready/rsp_valid.

Parameters:
- ADDR_WIDTH, 10, word-index width; memory holds 2**ADDR_WIDTH 32-bit words.
- LATENCY, 1, cycles from request accept to response for aligned accesses; legal range 1..8.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  stage can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as misaligned)
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data; the low byte/half/word is used
- req_pc  in  32  PC of the issuing instruction (logging only)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  access was misaligned; no memory effect

Behaviour:
- Word index = req_addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap.
- Lane order is little-endian: addr[1:0]=0 selects bits 7:0, 1 selects 15:8, 2 selects 23:16, 3 selects 31:24. A halfword at offset 0 uses bits 15:0; at offset 2 it uses 31:16.
- Alignment rules:
  - half requires addr[0]=0;
  - word requires addr[1:0]=0;
  - size 3 is always an error.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: req_ready=1. On req_valid, latch all request fields.
    - Error request: go to RESP at the next edge.
    - LATENCY=1: go directly to RESP.
    - Otherwise: go to BUSY with cnt=LATENCY-1.
  - BUSY: req_ready=0. Decrement cnt each edge. When cnt reaches 1, the next edge enters RESP.
  - Commit edge: on the edge entering RESP, a store merges only the selected lanes into the word and writes it. A load samples the word, then shifts and extends it into rsp_rdata.
  - RESP: rsp_valid=1. Outputs hold stable until an edge with rsp_ready=1, which returns to IDLE.
- Throughput: no accept occurs in the RESP cycle, so throughput is at most one access per LATENCY+1 cycles.
- Load after store to the same word sees the new data, since the commit happened on an earlier edge.
- Errors: rsp_err=1, rsp_rdata=0, no write, latency always 1.
- Reset:
  - FSM goes to IDLE, cnt=0.
  - Outputs: req_ready=1 after the reset edge; rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - All memory words are cleared to 0.
- Reset while BUSY aborts the access with no write. Reset has priority over any simultaneous request or rsp_ready.
- req_valid while not in IDLE is ignored; the requester must hold its request.

Optional Feature:
- Macro: MEM_STAGE_WRITE_LOG_EN.
- Defined: every committed store executes $display("@%h: *%h <= %h", pc, byte_addr_of_word, merged_word).
  - pc = latched req_pc.
  - byte_addr_of_word = {word_index, 2'b00} zero-extended to 32 bits.
  - merged_word = full 32-bit word after lane merge.
  - Error requests print nothing.
- Undefined: no display; logic is otherwise identical.

Test Plan:
- LATENCY=1: sw 0x12345678 to 0x10, then lw 0x10 → rsp_rdata=0x12345678, rsp_err=0. Each response arrives 1 edge after accept.
- After the word above: lb 0x13 → 0x00000012; lb 0x10 with data 0x80 in that lane → 0xFFFFFF80; lbu of the same → 0x00000080.
- sh 0xBEEF to 0x12 over 0x12345678 → word becomes 0xBEEF5678. lh 0x12 → 0xFFFFBEEF; lhu → 0x0000BEEF.
- Misaligned accesses: lw 0x11, sh 0x13 and size=3 each → rsp_err=1, rdata=0, one-cycle response, memory unchanged.
- LATENCY=4 with rsp_ready held low 3 cycles → rsp_valid rises 4 edges after accept, data stable while stalled, req_ready=0 throughout. Assert reset mid-BUSY on a store → memory unchanged and req_ready=1 after the reset edge.
- MEM_STAGE_WRITE_LOG_EN defined: sb 0xAA to 0x1001 with pc 0x3004 and ADDR_WIDTH=10 → logs "@00003004: *00000000 <= 0000aa00" (wrapped word index 0).
